trace_buffer_host: RTL and testbench

- Initiator that drives the system side of the stream trace buffer peripheral: control writes, status reads, data read bursts and data write bursts, all over valid/ready channels.
- Takes one command at a time from a host-side command channel, for example a debug-transport decoder.
- Returns read data, acknowledgements and errors on a single response stream.
- A watchdog aborts any transaction the peripheral stalls beyond a programmable bound.

---
 rtl/trace_buffer_host_if.sv | 74 +++++++
 rtl/trace_buffer_host.sv | 183 ++++++++++++++++++
 tb/tb_trace_buffer_host.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_buffer_host_if.sv
// Bundle of host-side and peripheral-side valid/ready channels of the trace buffer host.
// master = the host block itself, slave = its environment (command source and peripheral).
interface trace_buffer_host_if #(
  parameter int CTRL_WIDTH = 8,
  parameter int STAT_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [CTRL_WIDTH-1:0] cmd_arg;
  logic [LEN_WIDTH-1:0]  cmd_len;

  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [DATA_WIDTH-1:0] wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_last;
  logic                  rsp_err;

  logic                  ctrl_valid;
  logic                  ctrl_ready;
  logic [CTRL_WIDTH-1:0] ctrl;

  logic                  stat_valid;
  logic                  stat_ready;
  logic [STAT_WIDTH-1:0] stat;

  logic                  drd_valid;
  logic                  drd_ready;
  logic [DATA_WIDTH-1:0] drd_data;

  logic                  dwr_valid;
  logic                  dwr_ready;
  logic [DATA_WIDTH-1:0] dwr_data;

  modport master (
    input  cmd_valid, cmd_op, cmd_arg, cmd_len,
    output cmd_ready,
    input  wdata_valid, wdata,
    output wdata_ready,
    output rsp_valid, rsp_data, rsp_last, rsp_err,
    input  rsp_ready,
    output ctrl_valid, ctrl,
    input  ctrl_ready,
    input  stat_valid, stat,
    output stat_ready,
    input  drd_valid, drd_data,
    output drd_ready,
    output dwr_valid, dwr_data,
    input  dwr_ready
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_arg, cmd_len,
    input  cmd_ready,
    output wdata_valid, wdata,
    input  wdata_ready,
    input  rsp_valid, rsp_data, rsp_last, rsp_err,
    output rsp_ready,
    input  ctrl_valid, ctrl,
    output ctrl_ready,
    output stat_valid, stat,
    input  stat_ready,
    output drd_valid, drd_data,
    input  drd_ready,
    input  dwr_valid, dwr_data,
    output dwr_ready
  );
endinterface

// File: rtl/trace_buffer_host.sv
// Trace buffer host: runs one command at a time against the peripheral (control write,
// status read, read burst, write burst) and returns data/acks/errors on one response stream.
module trace_buffer_host #(
  parameter int CTRL_WIDTH = 8,
  parameter int STAT_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  trace_buffer_host_if.master bus
);
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0]      WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0]      WD_ONE  = WD_W'(1);
  localparam logic [LEN_WIDTH-1:0] CNT_ONE = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH:0]   ACC_ONE = (LEN_WIDTH+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CTRL, S_STAT, S_RD, S_WR, S_ACK, S_DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic                  cmd_ready_q;
  logic [CTRL_WIDTH-1:0] arg_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic [LEN_WIDTH:0]    acc_q;
  logic                  rsp_valid_q, rsp_last_q, rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  dwr_valid_q;
  logic [DATA_WIDTH-1:0] dwr_data_q;
  logic [WD_W-1:0]       wd_q;

  logic busy, abort, rsp_free, abort_go;
  logic ctrl_valid, stat_ready, drd_ready, dwr_valid, wdata_ready;
  logic cmd_xfer, ctrl_xfer, stat_xfer, drd_xfer, dwr_xfer, wdata_xfer, rsp_xfer;
  logic wr_done, periph_xfer, offer;

  assign busy     = (state_q == S_CTRL) || (state_q == S_STAT) ||
                    (state_q == S_RD)   || (state_q == S_WR);
  // Abort is driven off the registered count so the peripheral-side handshakes can be
  // dropped for the whole abort cycle without a combinational path through the readies.
  assign abort    = (TIMEOUT != 0) && busy && (wd_q == WD_MAX);
  assign rsp_free = !rsp_valid_q || bus.rsp_ready;
  assign abort_go = abort && rsp_free;

  assign ctrl_valid  = (state_q == S_CTRL) && !abort;
  assign stat_ready  = (state_q == S_STAT) && !abort;
  assign drd_ready   = (state_q == S_RD) && !abort && rsp_free;
  assign dwr_valid   = dwr_valid_q && !abort;
  assign wdata_ready = (state_q == S_WR) && !abort && (!dwr_valid_q || bus.dwr_ready) &&
                       (acc_q <= {1'b0, len_q});

  assign cmd_xfer   = cmd_ready_q && bus.cmd_valid;
  assign ctrl_xfer  = ctrl_valid  && bus.ctrl_ready;
  assign stat_xfer  = stat_ready  && bus.stat_valid;
  assign drd_xfer   = drd_ready   && bus.drd_valid;
  assign dwr_xfer   = dwr_valid   && bus.dwr_ready;
  assign wdata_xfer = wdata_ready && bus.wdata_valid;
  assign rsp_xfer   = rsp_valid_q && bus.rsp_ready;

  // Only one word is ever in flight, so the last host word going out ends the burst.
  assign wr_done     = dwr_xfer && (acc_q == ({1'b0, len_q} + ACC_ONE));
  assign periph_xfer = ctrl_xfer || stat_xfer || drd_xfer || dwr_xfer;
  assign offer       = ctrl_valid || stat_ready || drd_ready || dwr_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (cmd_xfer) begin
          case (bus.cmd_op)
            2'b00:   state_d = S_CTRL;
            2'b01:   state_d = S_STAT;
            2'b10:   state_d = S_RD;
            default: state_d = S_WR;
          endcase
        end
      S_CTRL:
        if (abort_go)       state_d = S_DRAIN;
        else if (ctrl_xfer) state_d = S_ACK;
      S_STAT:
        if (abort_go || stat_xfer) state_d = S_DRAIN;
      S_RD:
        if (abort_go || (drd_xfer && (cnt_q == '0))) state_d = S_DRAIN;
      S_WR:
        if (abort_go)     state_d = S_DRAIN;
        else if (wr_done) state_d = S_ACK;
      S_ACK, S_DRAIN:
        if (rsp_xfer && rsp_last_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == S_IDLE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      arg_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      dwr_valid_q <= 1'b0;
      dwr_data_q  <= '0;
      wd_q        <= '0;
    end else begin
      if (cmd_xfer) begin
        arg_q <= bus.cmd_arg;
        len_q <= bus.cmd_len;
        cnt_q <= bus.cmd_len;
        acc_q <= '0;
      end

      // Every load below only happens with the response register free or draining.
      if (abort_go) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= '0;
        rsp_last_q  <= 1'b1;
        rsp_err_q   <= 1'b1;
      end else if (ctrl_xfer || wr_done) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= '0;
        rsp_last_q  <= 1'b1;
        rsp_err_q   <= 1'b0;
      end else if (stat_xfer) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= DATA_WIDTH'(bus.stat);
        rsp_last_q  <= 1'b1;
        rsp_err_q   <= 1'b0;
      end else if (drd_xfer) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= bus.drd_data;
        rsp_last_q  <= (cnt_q == '0);
        rsp_err_q   <= 1'b0;
      end else if (rsp_xfer) begin
        rsp_valid_q <= 1'b0;
      end

      if (drd_xfer && (cnt_q != '0)) cnt_q <= cnt_q - CNT_ONE;
      if (wdata_xfer)                acc_q <= acc_q + ACC_ONE;

      if (abort) begin
        dwr_valid_q <= 1'b0;
      end else if (wdata_xfer) begin
        dwr_valid_q <= 1'b1;
        dwr_data_q  <= bus.wdata;
      end else if (dwr_xfer) begin
        dwr_valid_q <= 1'b0;
      end

      // Host-side stalls never reach offer, so they hold the count rather than advance it.
      if (!busy || periph_xfer)          wd_q <= '0;
      else if (offer && (wd_q != WD_MAX)) wd_q <= wd_q + WD_ONE;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.wdata_ready = wdata_ready;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_last    = rsp_last_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.ctrl_valid  = ctrl_valid;
  assign bus.ctrl        = arg_q;
  assign bus.stat_ready  = stat_ready;
  assign bus.drd_ready   = drd_ready;
  assign bus.dwr_valid   = dwr_valid;
  assign bus.dwr_data    = dwr_data_q;
endmodule

// File: tb/tb_trace_buffer_host.sv
// Directed bench for trace_buffer_host: control/status/read/write commands, watchdog abort
// and mid-burst reset, with hand-computed expectations.
module tb_trace_buffer_host;
  localparam int CW = 8, SW = 8, DW = 32, LW = 8, TO = 16;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  trace_buffer_host_if #(.CTRL_WIDTH(CW), .STAT_WIDTH(SW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  trace_buffer_host #(
    .CTRL_WIDTH(CW), .STAT_WIDTH(SW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT(TO)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [DW+1:0] rsp_q[$];   // {err, last, data}
  logic [DW-1:0] dwr_q[$];

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (bus.rsp_valid && bus.rsp_ready) rsp_q.push_back({bus.rsp_err, bus.rsp_last, bus.rsp_data});
      if (bus.dwr_valid && bus.dwr_ready) dwr_q.push_back(bus.dwr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [CW-1:0] arg, input logic [LW-1:0] len);
    int n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    bus.cmd_len   = len;
    @(negedge clk_i);
    while (!bus.cmd_ready && n < 20) begin
      tick;
      @(negedge clk_i);
      n++;
    end
    chk("cmd_ready", bus.cmd_ready, 1);
    tick;
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k, h, n;
    bit x, seen;
    logic [DW-1:0] w[4];
    w = '{32'hA, 32'hB, 32'hC, 32'hD};

    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_arg = 0; bus.cmd_len = 0;
    bus.wdata_valid = 0; bus.wdata = 0; bus.rsp_ready = 1;
    bus.ctrl_ready = 0; bus.stat_valid = 0; bus.stat = 0;
    bus.drd_valid = 0; bus.drd_data = 0; bus.dwr_ready = 0;

    // reset state
    repeat (2) tick;
    @(negedge clk_i);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_ctrl_valid", bus.ctrl_valid, 0);
    chk("rst_dwr_valid", bus.dwr_valid, 0);
    tick;
    rst_ni = 1'b1;
    tick;
    @(negedge clk_i);
    chk("post_rst_cmd_ready", bus.cmd_ready, 1);
    tick;

    // control write, ready after 3 wait cycles
    rsp_q.delete();
    send_cmd(2'b00, 8'h5A, 0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      bus.ctrl_ready = (i == 3);
      @(negedge clk_i);
      if (bus.ctrl_valid && bus.ctrl == 8'h5A) n++;
      tick;
    end
    bus.ctrl_ready = 0;
    chk("ctrl_hold_cycles", n, 4);
    @(negedge clk_i);
    chk("ctrl_ack_valid", bus.rsp_valid, 1);
    chk("ctrl_ack_data", bus.rsp_data, 0);
    chk("ctrl_ack_last", bus.rsp_last, 1);
    chk("ctrl_ack_err", bus.rsp_err, 0);
    chk("ctrl_valid_drop", bus.ctrl_valid, 0);
    tick;
    chk("ctrl_rsp_cnt", rsp_q.size(), 1);
    @(negedge clk_i);
    chk("ctrl_cmd_ready", bus.cmd_ready, 1);
    tick;

    // status read, status offered on the second cycle
    rsp_q.delete();
    send_cmd(2'b01, 0, 0);
    @(negedge clk_i);
    chk("stat_ready", bus.stat_ready, 1);
    tick;
    bus.stat_valid = 1; bus.stat = 8'h81;
    @(negedge clk_i);
    tick;
    bus.stat_valid = 0; bus.stat = 0;
    @(negedge clk_i);
    chk("stat_rsp_valid", bus.rsp_valid, 1);
    chk("stat_rsp_data", bus.rsp_data, 32'h81);
    chk("stat_rsp_last", bus.rsp_last, 1);
    tick;
    chk("stat_rsp_cnt", rsp_q.size(), 1);
    @(negedge clk_i);
    chk("stat_cmd_ready", bus.cmd_ready, 1);
    tick;

    // read burst len=3, response ready on alternate cycles
    rsp_q.delete();
    send_cmd(2'b10, 0, 3);
    k = 0;
    for (int cyc = 0; cyc < 60 && rsp_q.size() < 4; cyc++) begin
      bus.rsp_ready = (cyc % 2 == 1);
      bus.drd_valid = (k < 4);
      bus.drd_data  = 32'h10 + k;
      @(negedge clk_i);
      x = bus.drd_valid && bus.drd_ready;
      tick;
      if (x) k++;
    end
    bus.drd_valid = 0; bus.rsp_ready = 1;
    chk("rd_periph_words", k, 4);
    chk("rd_rsp_cnt", rsp_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rsp_q.size()) begin
        chk("rd_data", rsp_q[i][31:0], 32'h10 + i);
        chk("rd_last", rsp_q[i][32], (i == 3));
        chk("rd_err", rsp_q[i][33], 0);
      end
    end
    @(negedge clk_i);
    chk("rd_cmd_ready", bus.cmd_ready, 1);
    tick;

    // write burst len=2, four host words offered, DWR ready toggling
    rsp_q.delete(); dwr_q.delete();
    send_cmd(2'b11, 0, 2);
    h = 0; n = 0;
    for (int cyc = 0; cyc < 60 && n < 3; cyc++) begin
      bus.dwr_ready   = (cyc % 2 == 1);
      bus.wdata_valid = 1;
      bus.wdata       = w[h];
      @(negedge clk_i);
      x = bus.wdata_valid && bus.wdata_ready;
      tick;
      if (x) h++;
      if (rsp_q.size() > 0) n++;
    end
    bus.wdata_valid = 0; bus.dwr_ready = 0;
    chk("wr_host_words", h, 3);
    chk("wr_dwr_cnt", dwr_q.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < dwr_q.size()) chk("wr_dwr_data", dwr_q[i], w[i]);
    chk("wr_rsp_cnt", rsp_q.size(), 1);
    if (rsp_q.size() > 0) chk("wr_ack", rsp_q[0], {2'b01, 32'h0});

    // watchdog abort on a status read that never answers
    rsp_q.delete();
    send_cmd(2'b01, 0, 0);
    n = 0; seen = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk_i);
      if (bus.rsp_valid) begin
        seen = 1;
        chk("to_err", bus.rsp_err, 1);
        chk("to_last", bus.rsp_last, 1);
        chk("to_data", bus.rsp_data, 0);
        chk("to_stat_ready_drop", bus.stat_ready, 0);
        break;
      end
      if (bus.stat_ready) n++;
      tick;
    end
    chk("to_rsp_seen", seen, 1);
    chk("to_stall_cycles", n, 16);
    tick;
    @(negedge clk_i);
    chk("to_cmd_ready", bus.cmd_ready, 1);
    tick;
    bus.ctrl_ready = 1;
    send_cmd(2'b00, 8'h33, 0);
    @(negedge clk_i);
    chk("to_ctrl_valid", bus.ctrl_valid, 1);
    chk("to_ctrl_word", bus.ctrl, 8'h33);
    tick;
    bus.ctrl_ready = 0;
    @(negedge clk_i);
    chk("to_ctrl_ack_valid", bus.rsp_valid, 1);
    chk("to_ctrl_ack_err", bus.rsp_err, 0);
    chk("to_ctrl_ack_last", bus.rsp_last, 1);
    tick;

    // reset in the middle of a read burst
    send_cmd(2'b10, 0, 3);
    k = 0;
    for (int cyc = 0; cyc < 20 && k < 2; cyc++) begin
      bus.drd_valid = 1;
      bus.drd_data  = 32'h10 + k;
      @(negedge clk_i);
      x = bus.drd_valid && bus.drd_ready;
      tick;
      if (x) k++;
    end
    chk("rst_mid_words", k, 2);
    rst_ni = 1'b0;
    #1;
    rsp_q.delete();
    chk("rst_mid_rsp_valid", bus.rsp_valid, 0);
    chk("rst_mid_drd_ready", bus.drd_ready, 0);
    chk("rst_mid_cmd_ready", bus.cmd_ready, 0);
    tick;
    tick;
    rst_ni = 1'b1;
    tick;
    @(negedge clk_i);
    chk("rst_rel_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rel_drd_ready", bus.drd_ready, 0);
    repeat (3) tick;
    chk("rst_no_rsp", rsp_q.size(), 0);
    bus.drd_valid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
